// File: rtl/ift_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ift_trace_pkg
// Description : Shared widths, entry field offsets and sizing helpers for the
//               IFT trace recorder. An entry is packed as {ts, data, taint}
//               with the timestamp in the MSBs and the taint in the LSBs.
// Revision    : 1.0 - initial release
// ============================================================================
package ift_trace_pkg;

    localparam int DEF_DATA_W  = 2;
    localparam int DEF_TAINT_W = 32;
    localparam int DEF_TS_W    = 16;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_DROP_W  = 8;

    // Field offsets for the default widths.
    localparam int TAINT_LSB = 0;
    localparam int DATA_LSB  = TAINT_LSB + DEF_TAINT_W;
    localparam int TS_LSB    = DATA_LSB + DEF_DATA_W;

    // Number of bits needed to index 'value' entries (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int entry_w(input int ts_w, input int data_w, input int taint_w);
        return ts_w + data_w + taint_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ift_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ift_sync_fifo
// Description : Show-ahead single-clock FIFO. The head entry is held in a
//               register so it is visible on o_data in the cycle after it is
//               written, and the RAM is only ever read at an occupied index.
// Ports       : clk, rst_n (async, active-low)
//               i_push/i_data  - write request and entry
//               i_pop          - advance head (ignored when empty)
//               o_data         - current head entry
//               o_full/o_empty - occupancy flags
//               o_level        - occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module ift_sync_fifo
    import ift_trace_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8      // power of two, >= 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [clog2(DEPTH):0]   o_level
);

    localparam int C_AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_head;
    logic [C_AW:0]    r_wr_ptr;
    logic [C_AW:0]    r_rd_ptr;
    logic [C_AW:0]    w_level;
    logic [C_AW:0]    w_rd_next;
    logic [C_AW:0]    w_remain;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr == {~r_rd_ptr[C_AW], r_rd_ptr[C_AW-1:0]});
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_rd_next = r_rd_ptr + {{C_AW{1'b0}}, w_do_pop};
    // Entries already stored that survive this edge's pop.
    assign w_remain  = w_level - {{C_AW{1'b0}}, w_do_pop};

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[C_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            // Next head comes from a surviving stored entry if there is one,
            // otherwise from the entry being written; an emptied FIFO holds.
            if (w_remain != '0) begin
                r_head <= r_mem[w_rd_next[C_AW-1:0]];
            end else if (w_do_push) begin
                r_head <= i_data;
            end
        end
    end

    assign o_data  = r_head;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = w_level;

endmodule
`default_nettype wire

// File: rtl/ift_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module      : ift_trace_recorder
// Description : Samples {Q, Q_t} every enabled clock and pushes a timestamped
//               entry into a FIFO only when the sample changes, on the first
//               sample after enable/reset, or at the timestamp wrap point.
//               Entries that find the FIFO full are dropped and counted.
// Ports       : CLK, RST_N (async, active-low), EN (sampling enable),
//               CLR (clear OVERFLOW/DROP_CNT), Q/Q_t (sampled value/taint),
//               OUT_VALID/OUT_READY/OUT_DATA (entry stream {ts,data,taint}),
//               OVERFLOW (sticky drop flag), DROP_CNT (saturating drops),
//               LEVEL (FIFO occupancy)
// Revision    : 1.0 - initial release
// ============================================================================
module ift_trace_recorder
    import ift_trace_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TAINT_W = DEF_TAINT_W,
    parameter int TS_W    = DEF_TS_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DROP_W  = DEF_DROP_W
) (
    input  logic                                   CLK,
    input  logic                                   RST_N,
    input  logic                                   EN,
    input  logic                                   CLR,
    input  logic [DATA_W-1:0]                      Q,
    input  logic [TAINT_W-1:0]                     Q_t,
    output logic                                   OUT_VALID,
    input  logic                                   OUT_READY,
    output logic [entry_w(TS_W,DATA_W,TAINT_W)-1:0] OUT_DATA,
    output logic                                   OVERFLOW,
    output logic [DROP_W-1:0]                      DROP_CNT,
    output logic [clog2(DEPTH):0]                  LEVEL
);

    localparam int C_ENTRY_W  = entry_w(TS_W, DATA_W, TAINT_W);
    localparam int C_SAMPLE_W = DATA_W + TAINT_W;

    logic [TS_W-1:0]       r_ts;
    logic [C_SAMPLE_W-1:0] r_last;
    logic                  r_first;
    logic                  r_overflow;
    logic [DROP_W-1:0]     r_drop_cnt;

    logic [C_SAMPLE_W-1:0] w_sample;
    logic [C_ENTRY_W-1:0]  w_entry;
    logic                  w_record;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_drop;

    assign w_sample = {Q, Q_t};
    assign w_entry  = {r_ts, w_sample};

    // The wrap marker is forced so a consumer can count timestamp epochs even
    // when the sampled value never changes.
    assign w_record = EN && (r_first || (w_sample != r_last) || (r_ts == {TS_W{1'b1}}));
    assign w_pop    = OUT_READY && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO only drops
    // when nothing leaves.
    assign w_drop   = w_record && w_full && !w_pop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ts       <= '0;
            r_last     <= '0;
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (EN) begin
                r_ts <= r_ts + 1'b1;
                if (w_record) begin
                    r_last  <= w_sample;
                    r_first <= 1'b0;
                end
            end else begin
                // Re-enabling always records its first sample.
                r_first <= 1'b1;
            end

            // Clear takes priority over a drop in the same cycle.
            if (CLR) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {DROP_W{1'b1}}) begin
                    r_drop_cnt <= r_drop_cnt + 1'b1;
                end
            end
        end
    end

    ift_sync_fifo #(
        .WIDTH (C_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_push  (w_record),
        .i_data  (w_entry),
        .i_pop   (OUT_READY),
        .o_data  (OUT_DATA),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (LEVEL)
    );

    assign OUT_VALID = !w_empty;
    assign OVERFLOW  = r_overflow;
    assign DROP_CNT  = r_drop_cnt;

endmodule
`default_nettype wire
